hub75_rx_capture: RTL and testbench
===================================

Name: hub75_rx_capture

Overview:
- Receive end of the HUB75 panel interface: samples the 16-bit panel bus driven by our panel driver and reconstructs each shifted row.
- Publishes each row as a pixel stream tagged with column and row address.
- Used for loopback self-test on a second iCEBreaker and as a bench monitor for the driver. Runs on its own clock, asynchronous to the bus.

Parameters:
- COLS, 64, columns per row (shift clocks expected between latches); power of 2, ≤64.
- SYNC_STAGES, 2, synchronizer flops per bus bit; ≥2.

Ports:
- clk  in  1  receiver clock; must be ≥4× bus sclk frequency.
- reset  in  1  synchronous, active-high.
- panel_in  in  16  raw bus, driver bit order:
  - rgb0 = {panel_in[0], panel_in[1], panel_in[2]}
  - rgb1 = {panel_in[4], panel_in[5], panel_in[6]}
  - addr = {panel_in[15], panel_in[11:8]}
  - blank = [12], latch = [13], sclk = [14]; bits 3 and 7 ignored.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts when high with pix_valid.
- pix_x  out  6  column index in shift order (0 = first shifted).
- pix_y  out  5  row address.
- pix_rgb  out  6  {rgb1, rgb0}.
- pix_last  out  1  high on the pixel with pix_x = COLS-1.
- row_err  out  1  one-cycle pulse: latch seen with column count ≠ COLS.
- row_drop  out  1  one-cycle pulse: row committed while hold buffer still busy; row discarded.
- row_count  out  16  stats (see Optional Feature).
- err_count  out  16  stats (see Optional Feature).

Behaviour:
- Sync: all 16 bits pass SYNC_STAGES flops, then one history register.
  - Edge detects on sclk rise, latch rise and blank fall compare the last two synchronized words.
  - Data is taken from the same word that shows the sclk rise.
- Input FSM:
  - I_ALIGN (reset state): discard all sclk edges; on latch rise go to I_SHIFT with col_cnt = 0. No commit on this latch.
  - I_SHIFT, on sclk rise: if col_cnt < COLS, write {rgb1, rgb0} to shift_buf[col_cnt]; col_cnt saturates at COLS. Extra edges are ignored.
  - I_SHIFT, on latch rise: if col_cnt ≠ COLS, pulse row_err. Commit anyway; missing entries hold stale data. Clear col_cnt.
  - Commit with output FSM in O_EMPTY: copy shift_buf to hold_buf in one cycle; output FSM → O_ADDR.
  - Commit otherwise: pulse row_drop; hold_buf untouched.
  - sclk rise and latch rise in the same cycle: the shift is written first, then the commit includes it.
- Output FSM:
  - O_EMPTY: pix_valid = 0.
  - O_ADDR: on blank fall, capture addr into pix_y; → O_EMIT with emit_x = 0.
    - Rationale: the driver updates addr while blanked after the latch, so the address valid at unblank labels the latched row.
  - O_EMIT: pix_valid = 1; pix_x = emit_x; pix_rgb = hold_buf[emit_x] (registered output, stable while stalled).
    - Advance only on pix_valid & pix_ready.
    - Accept at emit_x = COLS-1 → O_EMPTY.
    - pix_ready low holds all pix_* outputs unchanged.
- Reset values:
  - Outputs: pix_valid, pix_x, pix_y, pix_rgb, pix_last, row_err, row_drop = 0; row_count = err_count = 0.
  - FSMs: I_ALIGN, O_EMPTY.
  - Synchronizer flops cleared, so no spurious edge after reset.
- Reset mid-row: partial row discarded; realign on the next latch.
- Latency: pix_valid rises 1 cycle after the clk edge that detects blank fall; first pixel ≤ SYNC_STAGES+3 clk after the bus blank fall.
- Throughput: 1 pixel/clk when pix_ready is held high, so a row drains before the next commit at the stated clock ratio.

Optional Feature:
- Macro: HUB75_RX_STATS_EN.
- Defined:
  - row_count increments (saturating at 0xFFFF) on each commit that reaches hold_buf.
  - err_count increments (saturating) on each row_err or row_drop pulse; both in the same cycle add 2, saturating.
- Undefined: row_count and err_count are tied to 0 and no counter logic is built. Ports remain present.

Test Plan:
- Reset, then drive 64 sclk edges with rgb6 = column index mod 8, then latch, then addr = 5 with blank fall → nothing emitted (align latch). Repeat the row → 64 pixels, pix_y = 5, pix_x 0..63, pix_rgb = x mod 8, pix_last only at x = 63; row_count = 1.
- 62 sclk edges then latch (after alignment) → row_err pulse once; pixels 62,63 carry previous row data; err_count = 1.
- 70 sclk edges then latch → row_err pulse once; pixels 0..63 = first 64 shifted values.
- Hold pix_ready = 0 through two complete rows → first row held at pix_x = 0, stable; second commit gives row_drop pulse. Release ready → only first row emitted.
- Toggle pix_ready every other cycle → 64 accepts over 127–128 cycles, pix_x strictly sequential, no duplicates or skips.
- Assert reset after 30 sclk edges, then send a full row → no output until the next latch realigns; pix_valid stays 0 during reset.

Source files
------------

// File: rtl/hub75_rx_capture.sv
// HUB75 receive-side capture: synchronizes the panel bus, rebuilds each latched row and
// replays it as a pixel stream. Define HUB75_RX_STATS_EN to build the row/error counters.
module hub75_rx_capture #(
  parameter int COLS        = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] panel_in,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [5:0]  pix_x,
  output logic [4:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        pix_last,
  output logic        row_err,
  output logic        row_drop,
  output logic [15:0] row_count,
  output logic [15:0] err_count
);
  localparam int            CW     = $clog2(COLS) + 1;
  localparam int            IW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] COLS_C = CW'(COLS);
  localparam logic [5:0]    LAST_X = 6'(COLS - 1);

  typedef enum logic       {I_ALIGN, I_SHIFT} in_state_t;
  typedef enum logic [1:0] {O_EMPTY, O_ADDR, O_EMIT} out_state_t;

  logic [15:0]   r_sync [SYNC_STAGES];
  logic [15:0]   r_hist;
  in_state_t     r_in_state;
  logic [CW-1:0] r_col_cnt;
  logic          r_ovf;
  logic          r_row_err, r_row_drop;
  out_state_t    r_out_state;
  logic          r_pix_valid, r_pix_last;
  logic [5:0]    r_pix_x, r_pix_rgb;
  logic [4:0]    r_pix_y;
  logic [5:0]    r_shift_buf [COLS];
  logic [5:0]    r_hold_buf  [COLS];

  logic [15:0]   w_cur;
  logic          w_sclk_rise, w_latch_rise, w_blank_fall;
  logic [5:0]    w_rgb;
  logic [4:0]    w_addr;
  logic          w_shift_en, w_ovf_next, w_commit, w_err, w_load, w_drop;
  logic [CW-1:0] w_cnt_next;
  logic [IW-1:0] w_col_idx;
  logic [5:0]    w_next_x;
  logic [5:0]    w_shift_next [COLS];
  logic          w_unused;

  assign w_cur        = r_sync[SYNC_STAGES-1];
  assign w_sclk_rise  = w_cur[14] & ~r_hist[14];
  assign w_latch_rise = w_cur[13] & ~r_hist[13];
  assign w_blank_fall = ~w_cur[12] & r_hist[12];
  assign w_rgb        = {w_cur[4], w_cur[5], w_cur[6], w_cur[0], w_cur[1], w_cur[2]};
  assign w_addr       = {w_cur[15], w_cur[11:8]};
  assign w_unused     = ^{r_hist[15], r_hist[11:0], w_cur[3], w_cur[7]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= panel_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= w_cur;
    end
  end

  // Edges past the last column only mark the row as overlong; the count itself saturates.
  assign w_shift_en = (r_in_state == I_SHIFT) && w_sclk_rise && (r_col_cnt != COLS_C);
  assign w_ovf_next = r_ovf | ((r_in_state == I_SHIFT) && w_sclk_rise && (r_col_cnt == COLS_C));
  assign w_cnt_next = r_col_cnt + CW'(w_shift_en);
  assign w_col_idx  = r_col_cnt[IW-1:0];
  assign w_commit   = (r_in_state == I_SHIFT) && w_latch_rise;
  assign w_err      = w_commit && ((w_cnt_next != COLS_C) || w_ovf_next);
  assign w_load     = w_commit && (r_out_state == O_EMPTY);
  assign w_drop     = w_commit && (r_out_state != O_EMPTY);

  // NOTE: every element gets a default before the conditional write, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < COLS; i++) w_shift_next[i] = r_shift_buf[i];
    if (w_shift_en) w_shift_next[w_col_idx] = w_rgb;
  end

  // NOTE: row buffers carry no reset; stale contents are never emitted without a commit first.
  always_ff @(posedge clk) begin
    r_shift_buf <= w_shift_next;
    if (w_load) r_hold_buf <= w_shift_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_state <= I_ALIGN;
      r_col_cnt  <= '0;
      r_ovf      <= 1'b0;
      r_row_err  <= 1'b0;
      r_row_drop <= 1'b0;
    end else begin
      r_row_err  <= w_err;
      r_row_drop <= w_drop;
      case (r_in_state)
        I_ALIGN: begin
          if (w_latch_rise) begin
            r_in_state <= I_SHIFT;
            r_col_cnt  <= '0;
            r_ovf      <= 1'b0;
          end
        end
        default: begin
          if (w_commit) begin
            r_col_cnt <= '0;
            r_ovf     <= 1'b0;
          end else begin
            r_col_cnt <= w_cnt_next;
            r_ovf     <= w_ovf_next;
          end
        end
      endcase
    end
  end

  assign w_next_x = r_pix_x + 6'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_state <= O_EMPTY;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_rgb   <= '0;
      r_pix_last  <= 1'b0;
    end else begin
      case (r_out_state)
        O_EMPTY: begin
          r_pix_valid <= 1'b0;
          if (w_load) r_out_state <= O_ADDR;
        end
        O_ADDR: begin
          if (w_blank_fall) begin
            r_pix_y     <= w_addr;
            r_pix_x     <= '0;
            r_pix_rgb   <= r_hold_buf[0];
            r_pix_last  <= (LAST_X == 6'd0);
            r_pix_valid <= 1'b1;
            r_out_state <= O_EMIT;
          end
        end
        O_EMIT: begin
          if (r_pix_valid && pix_ready) begin
            if (r_pix_x == LAST_X) begin
              r_pix_valid <= 1'b0;
              r_pix_last  <= 1'b0;
              r_out_state <= O_EMPTY;
            end else begin
              r_pix_x    <= w_next_x;
              r_pix_rgb  <= r_hold_buf[w_next_x[IW-1:0]];
              r_pix_last <= (w_next_x == LAST_X);
            end
          end
        end
        default: r_out_state <= O_EMPTY;
      endcase
    end
  end

`ifdef HUB75_RX_STATS_EN
  logic [15:0] r_row_count, r_err_count;
  logic [16:0] w_err_sum;

  assign w_err_sum = {1'b0, r_err_count} + 17'(w_err) + 17'(w_drop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_load && (r_row_count != 16'hFFFF)) r_row_count <= r_row_count + 16'd1;
      r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end
  end

  assign row_count = r_row_count;
  assign err_count = r_err_count;
`else
  assign row_count = '0;
  assign err_count = '0;
`endif

  assign pix_valid = r_pix_valid;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign pix_rgb   = r_pix_rgb;
  assign pix_last  = r_pix_last;
  assign row_err   = r_row_err;
  assign row_drop  = r_row_drop;

endmodule

// File: tb/tb_hub75_rx_capture.sv
// Self-checking bench for hub75_rx_capture: drives HUB75 rows and checks the pixel stream
// against a row-level model (queue of committed rows, shift-buffer image, busy flag).
module tb_hub75_rx_capture;
  localparam int COLS        = 64;
  localparam int SYNC_STAGES = 2;
  localparam int H           = 3;
`ifdef HUB75_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] panel_in;
  logic        pix_valid, pix_ready, pix_last, row_err, row_drop;
  logic [5:0]  pix_x, pix_rgb;
  logic [4:0]  pix_y;
  logic [15:0] row_count, err_count;

  always #5 clk = ~clk;

  hub75_rx_capture #(.COLS(COLS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .panel_in(panel_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_rgb(pix_rgb), .pix_last(pix_last), .row_err(row_err), .row_drop(row_drop),
    .row_count(row_count), .err_count(err_count)
  );

  typedef struct {
    logic [4:0] addr;
    logic [5:0] px [COLS];
  } row_t;

  typedef struct {
    int         n;
    logic [4:0] addr;
    bit         rnd;
    int         rmode;
    int         e_err;
    int         e_drop;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  row_t       exp_q[$];
  logic [5:0] m_shift [COLS];
  bit         m_aligned = 1'b0;
  bit         m_busy    = 1'b0;
  int         m_rows    = 0;
  int         m_errs    = 0;
  int         exp_x     = 0;
  int         err_pulses = 0;
  int         drop_pulses = 0;
  int         row_span  = 0;
  int         ready_mode = 0;
  logic [4:0] bus_addr  = 5'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic s, input logic l, input logic b,
                                      input logic [4:0] a, input logic [5:0] c);
    logic [15:0] w;
    logic [1:0]  junk;
    junk     = 2'($urandom);
    w        = '0;
    w[4]     = c[5];
    w[5]     = c[4];
    w[6]     = c[3];
    w[0]     = c[2];
    w[1]     = c[1];
    w[2]     = c[0];
    w[3]     = junk[0];
    w[7]     = junk[1];
    w[11:8]  = a[3:0];
    w[15]    = a[4];
    w[12]    = b;
    w[13]    = l;
    w[14]    = s;
    return w;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // One bus row: n shift clocks, then optionally blank / latch / new address / unblank.
  task automatic send_row(input int n, input logic [4:0] addr, input bit rnd, input bit do_latch,
                          output int e_err, output int e_drop);
    logic [5:0] vals[$];
    logic [5:0] v;
    bit         commit;
    int         k;
    row_t       r;
    e_err  = 0;
    e_drop = 0;
    commit = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 6'($urandom) : 6'(i % 8);
      vals.push_back(v);
      panel_in = enc(1'b0, 1'b0, 1'b0, bus_addr, v);
      wait_clk(H);
      panel_in = enc(1'b1, 1'b0, 1'b0, bus_addr, v);
      wait_clk(H);
    end
    panel_in = enc(1'b0, 1'b0, 1'b0, bus_addr, 6'd0);
    wait_clk(H);
    if (do_latch) begin
      panel_in = enc(1'b0, 1'b0, 1'b1, bus_addr, 6'd0);
      wait_clk(H);
      if (!m_aligned) m_aligned = 1'b1;
      else begin
        for (int i = 0; i < n && i < COLS; i++) m_shift[i] = vals[i];
        if (n != COLS) begin e_err = 1; m_errs++; end
        if (m_busy) begin
          e_drop = 1;
          m_errs++;
        end else begin
          r.addr = addr;
          r.px   = m_shift;
          exp_q.push_back(r);
          m_busy = 1'b1;
          m_rows++;
          commit = 1'b1;
        end
      end
      panel_in = enc(1'b0, 1'b1, 1'b1, bus_addr, 6'd0);
      wait_clk(H);
      bus_addr = addr;
      panel_in = enc(1'b0, 1'b0, 1'b1, bus_addr, 6'd0);
      wait_clk(H);
      panel_in = enc(1'b0, 1'b0, 1'b0, bus_addr, 6'd0);
      if (commit) begin
        k = 0;
        while (pix_valid !== 1'b1 && k < 12) begin
          @(negedge clk);
          k++;
        end
        check("blank_to_valid", 32'(k >= 1 && (k - 1) <= SYNC_STAGES + 3), 32'd1);
      end
      wait_clk(H);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || pix_valid !== 1'b0) && k < 3000) begin
      wait_clk(1);
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_stats();
    check("row_count", 32'(row_count), STATS ? 32'(m_rows) : 32'd0);
    check("err_count", 32'(err_count), STATS ? 32'(m_errs) : 32'd0);
  endtask

  // Consumer and pixel checker, sampled on the falling edge.
  initial begin : monitor
    logic        r;
    logic [18:0] held;
    bit          hold_prev;
    bit          in_row;
    int          first_cyc;
    hold_prev = 1'b0;
    in_row    = 1'b0;
    first_cyc = 0;
    held      = '0;
    pix_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (row_err === 1'b1) err_pulses++;
      if (row_drop === 1'b1) drop_pulses++;
      if (reset) begin
        check("valid_in_reset", 32'(pix_valid), 32'd0);
        hold_prev = 1'b0;
        in_row    = 1'b0;
        pix_ready = 1'b1;
      end else begin
        if (hold_prev)
          check("stall_stable", 32'({pix_valid, pix_x, pix_y, pix_rgb, pix_last}), 32'(held));
        case (ready_mode)
          0:       r = 1'b1;
          1:       r = ~pix_ready;
          2:       r = 1'($urandom);
          default: r = 1'b0;
        endcase
        pix_ready = r;
        if (pix_valid && !in_row) begin
          in_row    = 1'b1;
          first_cyc = cyc;
        end
        if (pix_valid && r) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pixel: x=%0d accepted with no row pending", pix_x);
          end else begin
            check("pix_x", 32'(pix_x), 32'(exp_x));
            check("pix_y", 32'(pix_y), 32'(exp_q[0].addr));
            check("pix_rgb", 32'(pix_rgb), 32'(exp_q[0].px[exp_x]));
            check("pix_last", 32'(pix_last), 32'(exp_x == COLS - 1));
            if (exp_x == COLS - 1) begin
              void'(exp_q.pop_front());
              exp_x    = 0;
              m_busy   = 1'b0;
              in_row   = 1'b0;
              row_span = cyc - first_cyc;
            end else exp_x++;
          end
        end
        hold_prev = pix_valid && !r;
        held      = {pix_valid, pix_x, pix_y, pix_rgb, pix_last};
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t       tbl [8];
    int         e_err, e_drop, e0, d0, n;
    logic [4:0] a;

    tbl[0] = '{64, 5'd5,  1'b0, 0, 0, 0};
    tbl[1] = '{64, 5'd5,  1'b0, 0, 0, 0};
    tbl[2] = '{62, 5'd3,  1'b1, 0, 1, 0};
    tbl[3] = '{70, 5'd9,  1'b1, 0, 1, 0};
    tbl[4] = '{64, 5'd31, 1'b1, 1, 0, 0};
    tbl[5] = '{64, 5'd16, 1'b1, 2, 0, 0};
    tbl[6] = '{1,  5'd0,  1'b1, 2, 1, 0};
    tbl[7] = '{64, 5'd21, 1'b0, 0, 0, 0};

    reset    = 1'b1;
    panel_in = '0;
    for (int i = 0; i < COLS; i++) m_shift[i] = '0;
    wait_clk(4);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_x", 32'(pix_x), 32'd0);
    check("rst_pix_y", 32'(pix_y), 32'd0);
    check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    check("rst_pix_last", 32'(pix_last), 32'd0);
    check("rst_row_err", 32'(row_err), 32'd0);
    check("rst_row_drop", 32'(row_drop), 32'd0);
    check_stats();
    reset = 1'b0;
    wait_clk(2);

    for (int i = 0; i < 8; i++) begin
      ready_mode = tbl[i].rmode;
      e0 = err_pulses;
      d0 = drop_pulses;
      send_row(tbl[i].n, tbl[i].addr, tbl[i].rnd, 1'b1, e_err, e_drop);
      wait_drain();
      check($sformatf("row%0d_err", i), 32'(err_pulses - e0), 32'(tbl[i].e_err));
      check($sformatf("row%0d_drop", i), 32'(drop_pulses - d0), 32'(tbl[i].e_drop));
      check_stats();
      if (tbl[i].rmode == 1)
        check("toggle_span", 32'(row_span >= 126 && row_span <= 127), 32'd1);
    end

    for (int i = 0; i < 6; i++) begin
      n = ($urandom_range(0, 1) == 0) ? COLS : int'($urandom_range(COLS - 6, COLS + 6));
      a = 5'($urandom);
      ready_mode = 2;
      e0 = err_pulses;
      d0 = drop_pulses;
      send_row(n, a, 1'b1, 1'b1, e_err, e_drop);
      wait_drain();
      check($sformatf("rnd%0d_err", i), 32'(err_pulses - e0), 32'(e_err));
      check($sformatf("rnd%0d_drop", i), 32'(drop_pulses - d0), 32'(e_drop));
      check_stats();
    end

    // Consumer stalled across two later commits: one full row, one short row.
    ready_mode = 3;
    e0 = err_pulses;
    d0 = drop_pulses;
    send_row(COLS, 5'd7, 1'b1, 1'b1, e_err, e_drop);
    wait_clk(4);
    check("stall_valid", 32'(pix_valid), 32'd1);
    check("stall_x", 32'(pix_x), 32'd0);
    check("stall_y", 32'(pix_y), 32'd7);
    check("stall_rgb", 32'(pix_rgb), 32'(exp_q[0].px[0]));
    send_row(COLS, 5'd8, 1'b1, 1'b1, e_err, e_drop);
    send_row(60, 5'd9, 1'b1, 1'b1, e_err, e_drop);
    check("stall_x_after", 32'(pix_x), 32'd0);
    check("stall_err", 32'(err_pulses - e0), 32'd1);
    check("stall_drop", 32'(drop_pulses - d0), 32'd2);
    check_stats();
    ready_mode = 0;
    wait_drain();
    check_stats();

    // Reset in the middle of a row, then realign.
    send_row(30, 5'd2, 1'b1, 1'b0, e_err, e_drop);
    reset     = 1'b1;
    m_aligned = 1'b0;
    m_busy    = 1'b0;
    exp_q.delete();
    exp_x     = 0;
    m_rows    = 0;
    m_errs    = 0;
    wait_clk(5);
    check_stats();
    reset = 1'b0;
    wait_clk(2);
    e0 = err_pulses;
    send_row(COLS, 5'd12, 1'b1, 1'b1, e_err, e_drop);
    wait_clk(20);
    check("realign_no_output", 32'(pix_valid), 32'd0);
    check("realign_no_err", 32'(err_pulses - e0), 32'd0);
    send_row(COLS, 5'd13, 1'b1, 1'b1, e_err, e_drop);
    wait_drain();
    check_stats();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
